// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions for the hazard controller: register-number width,
// multiply/divide occupancy defaults, and the md_sequencer state encoding.
package hazard_controller_pkg;

    localparam int REG_W          = 5;
    localparam int CNT_W          = 6;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    typedef logic [REG_W-1:0] reg_num_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A producer only matters when it actually names a real register; $0 is hardwired.
    function automatic logic reg_hit(input reg_num_t src, input reg_num_t dst);
        return (dst != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_controller_md_sequencer.sv
// Multiply/divide occupancy tracker: a two-state FSM with a 6-bit down-counter
// that reports busy for the full operation and pulses done on the last cycle.
module md_sequencer
    import hazard_controller_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = div ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                // A start seen here, including on the final cycle, is dropped.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: load-use, branch-compare and mult/div stalls plus
// decode-stage branch operand forwarding from the memory stage.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             MdUseD,
    input  logic             MdStartE,
    input  logic             MdDivE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MdBusy,
    output logic             MdDone
);

    logic hit_e, hit_m;
    logic lwstall, brstall, mdstall, stall;

    md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_sequencer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (MdStartE),
        .div   (MdDivE),
        .busy  (MdBusy),
        .done  (MdDone)
    );

    assign hit_e = reg_hit(rsD, WriteRegE) | reg_hit(rtD, WriteRegE);
    assign hit_m = reg_hit(rsD, WriteRegM) | reg_hit(rtD, WriteRegM);

    assign lwstall = MemtoRegE & RegWriteE & hit_e;
    // A branch resolved in decode cannot use an ALU result still in execute,
    // nor a load result that only becomes available at the end of memory.
    assign brstall = BranchD & ((RegWriteE & hit_e) | (MemtoRegM & hit_m));
    assign mdstall = MdUseD & (MdBusy | MdStartE);
    assign stall   = lwstall | brstall | mdstall;

    assign StallF    = stall;
    assign StallD    = stall;
    assign FlushE    = stall;
    assign ForwardAD = RegWriteM & reg_hit(rsD, WriteRegM);
    assign ForwardBD = RegWriteM & reg_hit(rtD, WriteRegM);

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: expected output vectors are queued
// when stimulus is applied and popped when the DUT outputs are sampled.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rsD, rtD, WriteRegE, WriteRegM;
    logic       RegWriteE, RegWriteM, MemtoRegE, MemtoRegM;
    logic       BranchD, MdUseD, MdStartE, MdDivE;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, MdDone;

    // Output vector layout: {StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, MdDone}
    localparam logic [6:0] STALL = 7'b111_0_0_0_0;
    localparam logic [6:0] FA    = 7'b000_1_0_0_0;
    localparam logic [6:0] FB    = 7'b000_0_1_0_0;
    localparam logic [6:0] BUSY  = 7'b000_0_0_1_0;
    localparam logic [6:0] DONE  = 7'b000_0_0_0_1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [6:0]  v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [6:0] outs;

    assign outs = {StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, MdDone};

    hazard_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsD       (rsD),
        .rtD       (rtD),
        .WriteRegE (WriteRegE),
        .WriteRegM (WriteRegM),
        .RegWriteE (RegWriteE),
        .RegWriteM (RegWriteM),
        .MemtoRegE (MemtoRegE),
        .MemtoRegM (MemtoRegM),
        .BranchD   (BranchD),
        .MdUseD    (MdUseD),
        .MdStartE  (MdStartE),
        .MdDivE    (MdDivE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .MdBusy    (MdBusy),
        .MdDone    (MdDone)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; WriteRegE = '0; WriteRegM = '0;
        RegWriteE = 0; RegWriteM = 0; MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; MdUseD = 0; MdStartE = 0; MdDivE = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            clear_inputs();
            rst_n = 1'b0;
            rsD = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1;
            MdUseD = 1'b1; MdStartE = 1'b1; MdDivE = 1'b1;
            sb.push_back({32'(k), STALL | FA});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.v) begin
                errors++;
                $display("FAIL reset cyc %0d: got %b expected %b", e.cyc, outs, e.v);
            end
        end
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
        sb.push_back({32'd3, 7'b0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (outs !== e.v) begin
            errors++;
            $display("FAIL reset_release cyc %0d: got %b expected %b", e.cyc, outs, e.v);
        end
    endtask

    task automatic test_lwstall();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            clear_inputs();
            MemtoRegE = 1'b1; RegWriteE = 1'b1;
            case (k)
                0: begin rsD = 5'd5; WriteRegE = 5'd5; sb.push_back({32'(k), STALL}); end
                1: begin rsD = 5'd0; WriteRegE = 5'd0; sb.push_back({32'(k), 7'b0}); end
                2: begin rsD = 5'd3; rtD = 5'd12; WriteRegE = 5'd12; sb.push_back({32'(k), STALL}); end
                3: begin rsD = 5'd5; WriteRegE = 5'd5; RegWriteE = 1'b0; sb.push_back({32'(k), 7'b0}); end
                default: begin rsD = 5'd5; WriteRegE = 5'd6; sb.push_back({32'(k), 7'b0}); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.v) begin
                errors++;
                $display("FAIL lwstall case %0d: got %b expected %b", e.cyc, outs, e.v);
            end
        end
    endtask

    task automatic test_branch_forward();
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            clear_inputs();
            case (k)
                0: begin
                    BranchD = 1; rtD = 5'd9; WriteRegM = 5'd9; RegWriteM = 1;
                    sb.push_back({32'(k), FB});
                end
                1: begin
                    BranchD = 1; rtD = 5'd9; WriteRegM = 5'd9; RegWriteM = 1; MemtoRegM = 1;
                    sb.push_back({32'(k), STALL | FB});
                end
                2: begin
                    BranchD = 1; rsD = 5'd4; WriteRegE = 5'd4; RegWriteE = 1;
                    sb.push_back({32'(k), STALL});
                end
                3: begin
                    BranchD = 1; RegWriteE = 1; RegWriteM = 1; MemtoRegM = 1;
                    sb.push_back({32'(k), 7'b0});
                end
                4: begin
                    rsD = 5'd7; rtD = 5'd7; WriteRegM = 5'd7; RegWriteM = 1;
                    sb.push_back({32'(k), FA | FB});
                end
                default: begin
                    rsD = 5'd4; WriteRegE = 5'd4; RegWriteE = 1;
                    sb.push_back({32'(k), 7'b0});
                end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.v) begin
                errors++;
                $display("FAIL branch_forward case %0d: got %b expected %b", e.cyc, outs, e.v);
            end
        end
    endtask

    task automatic test_mul();
        exp_t e;
        for (int k = 0; k <= 6; k++) begin
            next_cycle();
            clear_inputs();
            MdStartE = (k == 0);
            sb.push_back({32'(k), ((k >= 1 && k <= 4) ? BUSY : 7'b0) | ((k == 4) ? DONE : 7'b0)});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.v) begin
                errors++;
                $display("FAIL mul cyc %0d: got %b expected %b", e.cyc, outs, e.v);
            end
        end
    endtask

    task automatic test_div_stall();
        exp_t e;
        for (int k = 0; k <= 34; k++) begin
            next_cycle();
            clear_inputs();
            MdUseD   = 1'b1;
            MdStartE = (k == 0) || (k == 10) || (k == 32);
            MdDivE   = (k == 0);
            sb.push_back({32'(k), ((k <= 32) ? STALL : 7'b0) |
                                  ((k >= 1 && k <= 32) ? BUSY : 7'b0) |
                                  ((k == 32) ? DONE : 7'b0)});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.v) begin
                errors++;
                $display("FAIL div_stall cyc %0d: got %b expected %b", e.cyc, outs, e.v);
            end
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        for (int k = 0; k <= 22; k++) begin
            next_cycle();
            clear_inputs();
            rst_n    = (k != 15);
            MdStartE = (k == 0) || (k == 17);
            MdDivE   = (k < 17);
            sb.push_back({32'(k), (((k >= 1 && k <= 14) || (k >= 18 && k <= 21)) ? BUSY : 7'b0) |
                                  ((k == 21) ? DONE : 7'b0)});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.v) begin
                errors++;
                $display("FAIL reset_abort cyc %0d: got %b expected %b", e.cyc, outs, e.v);
            end
        end
    endtask

    task automatic test_combined_stall();
        exp_t e;
        for (int k = 0; k <= 5; k++) begin
            next_cycle();
            clear_inputs();
            MdUseD = 1'b1;
            if (k <= 1) begin
                rsD = 5'd5; WriteRegE = 5'd5; MemtoRegE = 1; RegWriteE = 1;
            end
            MdStartE = (k == 0);
            sb.push_back({32'(k), ((k <= 4) ? STALL : 7'b0) |
                                  ((k >= 1 && k <= 4) ? BUSY : 7'b0) |
                                  ((k == 4) ? DONE : 7'b0)});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (outs !== e.v) begin
                errors++;
                $display("FAIL combined_stall cyc %0d: got %b expected %b", e.cyc, outs, e.v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_lwstall();
        test_branch_forward();
        test_mul();
        test_div_stall();
        test_reset_abort();
        test_combined_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MUL_CYCLES, default 4: multiply occupancy in cycles; legal range 2..63.
REQ-002 Parameter DIV_CYCLES, default 32: divide occupancy in cycles; legal range 2..63.
REQ-003 clk  in  1  single pipeline clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rsD, rtD  in  5  decode-stage source register numbers.
REQ-006 WriteRegE, WriteRegM  in  5  destination register numbers in execute and memory stages.
REQ-007 RegWriteE, RegWriteM  in  1  register-write enable in execute and memory stages.
REQ-008 MemtoRegE, MemtoRegM  in  1  load-instruction flag in execute and memory stages.
REQ-009 BranchD  in  1  decode stage holds a branch that compares registers in decode.
REQ-010 MdUseD  in  1  decode stage holds mult/div/mfhi/mflo.
REQ-011 MdStartE  in  1  execute stage launches a multiply/divide this cycle.
REQ-012 MdDivE  in  1  qualifies MdStartE: 1 = divide, 0 = multiply.
REQ-013 StallF, StallD  out  1  hold the fetch and decode pipeline registers.
REQ-014 FlushE  out  1  clear the execute pipeline register to a bubble.
REQ-015 ForwardAD, ForwardBD  out  1  select the memory-stage ALU result for the decode-stage branch comparison.
REQ-016 MdBusy  out  1  multiply/divide unit is occupied.
REQ-017 MdDone  out  1  one-cycle pulse; HI/LO results are written this cycle.

Function
REQ-018 lwstall SHALL equal MemtoRegE & RegWriteE & (WriteRegE != 0) & ((rsD == WriteRegE) | (rtD == WriteRegE)).
REQ-019 brstall SHALL equal BranchD & (((RegWriteE & WriteRegE != 0) & (rsD == WriteRegE | rtD == WriteRegE)) | ((MemtoRegM & WriteRegM != 0) & (rsD == WriteRegM | rtD == WriteRegM))).
REQ-020 mdstall SHALL equal MdUseD & (state == MD_BUSY | MdStartE).
REQ-021 StallF, StallD and FlushE SHALL each equal lwstall | brstall | mdstall, combinationally, in the same cycle.
REQ-022 ForwardAD SHALL equal (rsD != 0) & RegWriteM & (rsD == WriteRegM); ForwardBD SHALL be the same with rtD; both combinational.
REQ-023 The FSM SHALL have two states, IDLE and MD_BUSY, plus a 6-bit down-counter cnt.
REQ-024 In IDLE with MdStartE=1, the next state SHALL be MD_BUSY, and cnt SHALL load DIV_CYCLES-1 if MdDivE=1, else MUL_CYCLES-1.
REQ-025 In MD_BUSY with cnt != 0, cnt SHALL decrement by 1 per cycle.
REQ-026 In MD_BUSY with cnt == 0, the next state SHALL be IDLE, and MdDone SHALL be 1 for that cycle only.
REQ-027 MdBusy SHALL equal (state == MD_BUSY); occupancy SHALL therefore be exactly MUL_CYCLES or DIV_CYCLES cycles after the start edge.
REQ-028 MdStartE asserted while in MD_BUSY SHALL be ignored: no reload, no state change.
REQ-029 MdStartE in the same cycle that MD_BUSY exits with cnt == 0 SHALL be ignored; the start is accepted only from IDLE.
REQ-030 All stall terms active together SHALL produce a single stall; no priority between them applies.
REQ-031 Register 0 SHALL never cause a stall or a forward.

Reset
REQ-032 While rst_n == 0: state = IDLE, cnt = 0, MdBusy = 0, MdDone = 0.
REQ-033 While rst_n == 0, the combinational outputs SHALL follow their inputs with state forced to IDLE.
REQ-034 Reset asserted mid-operation SHALL abort the occupancy immediately, with no MdDone pulse.

Structure
REQ-035 The shared pipeline package SHALL hold the FSM state encoding (IDLE=0, MD_BUSY=1), the 5-bit register-number width and the MUL_CYCLES/DIV_CYCLES defaults.
REQ-036 The occupancy counter with its FSM SHALL be one sub-module, md_sequencer; the stall and forward logic stays in the top level.

Verification
REQ-037 rsD=5, WriteRegE=5, MemtoRegE=1, RegWriteE=1 -> StallF=StallD=FlushE=1; same stimulus with rsD=0 and WriteRegE=0 -> all 0.
REQ-038 BranchD=1, rtD=9, WriteRegM=9, RegWriteM=1, MemtoRegM=0 -> ForwardBD=1 and no stall; the same with MemtoRegM=1 -> stall=1.
REQ-039 MdStartE=1, MdDivE=0 pulse at cycle 0 -> MdBusy=1 in cycles 1..4, MdDone=1 in cycle 4 only, MdBusy=0 from cycle 5.
REQ-040 Start a divide, hold MdUseD=1 -> stall held for the start cycle plus 32 cycles, released the cycle after MdDone; a second MdStartE at cycle 10 does not extend occupancy.
REQ-041 Start a divide, drop rst_n at cycle 15 for 1 cycle -> MdBusy=0 immediately, no MdDone, and a fresh multiply started afterwards completes in 4 cycles.
REQ-042 lwstall and mdstall asserted in the same cycle -> exactly one stall cycle per cycle, and FlushE=1.
